perceptron_seq: RTL and testbench

PERCEPTRON_SEQ -- requirements
Module: perceptron_seq

---
 rtl/perceptron_pkg.sv | 36 +++
 rtl/perceptron_mac.sv | 37 +++
 rtl/perceptron_seq.sv | 139 +++++++++++++
 tb/tb_perceptron_seq.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// perceptron_pkg: FSM states, accumulator sizing and saturation helpers.
// Define PERCEPTRON_LEARN_EN to add the UPDATE state for online learning.
package perceptron_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MAC    = 2'd1,
    S_DECIDE = 2'd2
`ifdef PERCEPTRON_LEARN_EN
    ,
    S_UPDATE = 2'd3
`endif
  } state_e;

  function automatic int acc_width(input int n, input int k);
    return 2 * n + $clog2(k) + 1;
  endfunction

  // Add two values and clamp into the signed range of a w-bit register.
  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 w
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/perceptron_mac.sv
// perceptron_mac: signed accumulator, one x*w product per enabled cycle.
// clr preloads the bias; x is unsigned and zero-extended before multiply.
module perceptron_mac
  import perceptron_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [AW-1:0] bias,
  input  logic        [N-1:0]  xi,
  input  logic signed [N-1:0]  wi,
  output logic signed [AW-1:0] acc
);

  logic signed [2*N:0] xe;
  logic signed [2*N:0] we;
  logic signed [2*N:0] prod;

  assign xe   = {{(N + 1){1'b0}}, xi};
  assign we   = {{(N + 1){wi[N-1]}}, wi};
  assign prod = xe * we;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= bias;
    end else if (en) begin
      acc <= acc + {{(AW - 2*N - 1){prod[2*N]}}, prod};
    end
  end

endmodule

// File: rtl/perceptron_seq.sv
// perceptron_seq: sequential perceptron, one MAC per cycle over K inputs.
// Optional online learning is compiled in with PERCEPTRON_LEARN_EN.
module perceptron_seq
  import perceptron_pkg::*;
#(
  parameter int N      = 8,
  parameter int K      = 4,
  parameter int THRESH = 320
) (
  input  logic                             clk_in,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [K*N-1:0]                   x,
  input  logic                             target,
  input  logic                             w_load,
  input  logic [K*N-1:0]                   w_in,
  input  logic signed [acc_width(N,K)-1:0] b_in,
  output logic                             out_valid,
  output logic                             out,
  output logic signed [acc_width(N,K)-1:0] acc_out
);

  localparam int AW = acc_width(N, K);
  localparam int IW = $clog2(K);
  localparam logic signed [AW-1:0] TH   = AW'(THRESH);
  localparam logic [IW-1:0]        LAST = IW'(K - 1);

  state_e                state;
  logic [IW-1:0]         idx;
  logic [K*N-1:0]        x_r;
  logic signed [N-1:0]   w_r [K];
  logic signed [AW-1:0]  b_r;
  logic signed [AW-1:0]  acc;
  logic                  accept;
  logic                  mac_en;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_ready && in_valid && !w_load;
  assign mac_en   = (state == S_MAC);

  perceptron_mac #(
    .N  (N),
    .AW (AW)
  ) u_mac (
    .clk  (clk_in),
    .rst  (rst),
    .clr  (accept),
    .en   (mac_en),
    .bias (b_r),
    .xi   (x_r[idx*N +: N]),
    .wi   (w_r[idx]),
    .acc  (acc)
  );

`ifdef PERCEPTRON_LEARN_EN
  logic                 tgt_r;
  logic signed [N-1:0]  w_upd [K];
  logic signed [AW-1:0] b_upd;

  // Move each weight toward the target by x_i, clamped to N bits.
  always_comb begin
    logic signed [63:0] wa;
    logic signed [63:0] dx;
    logic signed [63:0] ba;
    wa = '0;
    dx = '0;
    for (int i = 0; i < K; i++) begin
      wa = {{(64 - N){w_r[i][N-1]}}, w_r[i]};
      dx = {{(64 - N){1'b0}}, x_r[i*N +: N]};
      if (!tgt_r) dx = -dx;
      w_upd[i] = N'(sat_add(wa, dx, N));
    end
    ba    = {{(64 - AW){b_r[AW-1]}}, b_r};
    b_upd = AW'(sat_add(ba, tgt_r ? 64'sd1 : -64'sd1, AW));
  end
`else
  logic unused_target;
  assign unused_target = target;
`endif

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      x_r       <= '0;
      b_r       <= '0;
      out_valid <= 1'b0;
      out       <= 1'b0;
      acc_out   <= '0;
      for (int i = 0; i < K; i++) w_r[i] <= '0;
`ifdef PERCEPTRON_LEARN_EN
      tgt_r     <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (w_load) begin
            for (int i = 0; i < K; i++) w_r[i] <= w_in[i*N +: N];
            b_r <= b_in;
          end else if (in_valid) begin
            x_r   <= x;
            idx   <= '0;
            state <= S_MAC;
`ifdef PERCEPTRON_LEARN_EN
            tgt_r <= target;
`endif
          end
        end
        S_MAC: begin
          idx <= idx + 1'b1;
          if (idx == LAST) state <= S_DECIDE;
        end
        S_DECIDE: begin
          out       <= (acc >= TH);
          acc_out   <= acc;
          out_valid <= 1'b1;
`ifdef PERCEPTRON_LEARN_EN
          state     <= S_UPDATE;
`else
          state     <= S_IDLE;
`endif
        end
`ifdef PERCEPTRON_LEARN_EN
        S_UPDATE: begin
          if (out != tgt_r) begin
            for (int i = 0; i < K; i++) w_r[i] <= w_upd[i];
            b_r <= b_upd;
          end
          state <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_seq.sv
// tb_perceptron_seq: scoreboard bench for perceptron_seq (N=8, K=4).
// Learning scenarios run only when PERCEPTRON_LEARN_EN is defined.
module tb_perceptron_seq;

  localparam int N  = 8;
  localparam int K  = 4;
  localparam int AW = 2 * N + 2 + 1;
  localparam int TH = 320;
`ifdef PERCEPTRON_LEARN_EN
  localparam int PERIOD = K + 3;
`else
  localparam int PERIOD = K + 2;
`endif

  logic                 clk_in = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [K*N-1:0]       x = '0;
  logic                 target = 1'b0;
  logic                 w_load = 1'b0;
  logic [K*N-1:0]       w_in = '0;
  logic [AW-1:0]        b_in = '0;
  logic                 out_valid;
  logic                 out;
  logic signed [AW-1:0] acc_out;

  typedef struct {
    int acc;
    bit o;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   mw[K];
  int   mb = 0;

  perceptron_seq #(
    .N      (N),
    .K      (K),
    .THRESH (TH)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .target    (target),
    .w_load    (w_load),
    .w_in      (w_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out       (out),
    .acc_out   (acc_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [K*N-1:0] pack(input int a0, input int a1,
                                          input int a2, input int a3);
    logic [K*N-1:0] p;
    p[7:0]   = a0[7:0];
    p[15:8]  = a1[7:0];
    p[23:16] = a2[7:0];
    p[31:24] = a3[7:0];
    return p;
  endfunction

  function automatic exp_t model(input logic [K*N-1:0] xv);
    exp_t e;
    int   s;
    s = mb;
    for (int i = 0; i < K; i++) s += int'(xv[i*N +: N]) * mw[i];
    e.acc = s;
    e.o   = (s >= TH);
    return e;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic load(input int w0, input int w1, input int w2,
                      input int w3, input int b);
    wait_idle();
    w_in   = pack(w0, w1, w2, w3);
    b_in   = b[AW-1:0];
    w_load = 1'b1;
    tick();
    w_load = 1'b0;
    mw[0] = w0; mw[1] = w1; mw[2] = w2; mw[3] = w3;
    mb = b;
  endtask

  // tgt < 0 picks the target that matches the expected class.
  task automatic send(input logic [K*N-1:0] xv, input int tgt);
    exp_t e;
    e = model(xv);
    x = xv;
    target = (tgt < 0) ? e.o : tgt[0];
    in_valid = 1'b1;
    wait_idle();
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_ready: in_ready=%0b required 1", in_ready);
    end
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 30);
  endtask

  task automatic test_reset();
    exp_t e;
    int   lat;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checks += 4;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready: got %0b required 1", in_ready);
    end
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid: got %0b required 0", out_valid);
    end
    if (out !== 1'b0) begin
      errors++; $display("FAIL rst_out: got %0b required 0", out);
    end
    if (acc_out !== '0) begin
      errors++; $display("FAIL rst_acc: got %0d required 0", acc_out);
    end
    send(pack(5, 6, 7, 8), -1);
    wait_out(lat);
    e = sb.pop_front();
    checks += 2;
    if (acc_out !== AW'(e.acc)) begin
      errors++; $display("FAIL rst_zero_w: got %0d required %0d", acc_out, e.acc);
    end
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_zero_valid: got %0b required 1", out_valid);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    int   lat;
    load(10, 10, 0, 0, 0);
    send(pack(20, 20, 0, 0), -1);
    wait_out(lat);
    e = sb.pop_front();
    checks += 3;
    if (lat != K + 1) begin
      errors++; $display("FAIL basic_latency: got %0d required %0d", lat, K + 1);
    end
    if (acc_out !== AW'(e.acc) || e.acc != 400) begin
      errors++; $display("FAIL basic_acc: got %0d required 400", acc_out);
    end
    if (out !== 1'b1) begin
      errors++; $display("FAIL basic_out: got %0b required 1", out);
    end
    tick();
    checks += 2;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_pulse: got %0b required 0", out_valid);
    end
    if (acc_out !== AW'(e.acc)) begin
      errors++; $display("FAIL basic_hold: got %0d required %0d", acc_out, e.acc);
    end
  endtask

  task automatic test_threshold();
    exp_t e;
    int   lat;
    send(pack(10, 10, 0, 0), -1);
    wait_out(lat);
    e = sb.pop_front();
    checks += 2;
    if (acc_out !== AW'(e.acc) || e.acc != 200) begin
      errors++; $display("FAIL thr_below_acc: got %0d required 200", acc_out);
    end
    if (out !== 1'b0) begin
      errors++; $display("FAIL thr_below_out: got %0b required 0", out);
    end
    send(pack(16, 16, 0, 0), -1);
    wait_out(lat);
    e = sb.pop_front();
    checks += 3;
    if (lat != K + 1) begin
      errors++; $display("FAIL thr_latency: got %0d required %0d", lat, K + 1);
    end
    if (acc_out !== AW'(e.acc) || e.acc != 320) begin
      errors++; $display("FAIL thr_equal_acc: got %0d required 320", acc_out);
    end
    if (out !== 1'b1) begin
      errors++; $display("FAIL thr_equal_out: got %0b required 1", out);
    end
  endtask

  task automatic test_signed();
    exp_t e;
    int   lat;
    load(-128, 0, 0, 0, 0);
    send(pack(255, 0, 0, 0), -1);
    wait_out(lat);
    e = sb.pop_front();
    checks += 2;
    if (acc_out !== AW'(e.acc) || e.acc != -32640) begin
      errors++; $display("FAIL signed_acc: got %0d required -32640", acc_out);
    end
    if (out !== 1'b0) begin
      errors++; $display("FAIL signed_out: got %0b required 0", out);
    end
  endtask

  task automatic test_back_to_back();
    logic [K*N-1:0] samples [4];
    exp_t           e;
    int             cyc, last, si, outs, lat;
    logic           rdy;
    samples[0] = pack(10, 20, 30, 40);
    samples[1] = pack(1, 1, 1, 1);
    samples[2] = pack(200, 0, 0, 9);
    samples[3] = pack(0, 50, 50, 0);
    load(1, 2, 3, 4, 7);
    cyc = 0; last = -1; si = 0; outs = 0;
    x = samples[0];
    target = model(samples[0]).o;
    in_valid = 1'b1;
    while (outs < 4 && cyc < 200) begin
      rdy = in_ready;
      tick();
      cyc++;
      if (rdy && in_valid) begin
        sb.push_back(model(x));
        if (last >= 0) begin
          checks++;
          if (cyc - last != PERIOD) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d required %0d", cyc - last, PERIOD);
          end
        end
        last = cyc;
        si++;
        if (si == 4) in_valid = 1'b0;
        else begin
          x = samples[si];
          target = model(samples[si]).o;
        end
      end
      if (out_valid) begin
        e = sb.pop_front();
        outs++;
        checks += 2;
        if (acc_out !== AW'(e.acc)) begin
          errors++; $display("FAIL b2b_acc: got %0d required %0d", acc_out, e.acc);
        end
        if (out !== e.o) begin
          errors++; $display("FAIL b2b_out: got %0b required %0b", out, e.o);
        end
      end
    end
    in_valid = 1'b0;
    checks += 2;
    if (outs != 4 || si != 4) begin
      errors++; $display("FAIL b2b_count: got %0d outs %0d accepts required 4", outs, si);
    end
    if (sb.size() != 0) begin
      errors++; $display("FAIL b2b_queue: got %0d left required 0", sb.size());
      sb.delete();
    end
    // Load and sample together: the load must take this edge.
    wait_idle();
    w_in = pack(2, 2, 2, 2);
    b_in = 19'sd5;
    w_load = 1'b1;
    x = pack(10, 10, 10, 10);
    target = 1'b0;
    in_valid = 1'b1;
    tick();
    w_load = 1'b0;
    mw[0] = 2; mw[1] = 2; mw[2] = 2; mw[3] = 2;
    mb = 5;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL load_wins_ready: got %0b required 1", in_ready);
    end
    sb.push_back(model(x));
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    e = sb.pop_front();
    checks += 2;
    if (lat != K + 1) begin
      errors++; $display("FAIL load_wins_latency: got %0d required %0d", lat, K + 1);
    end
    if (acc_out !== AW'(e.acc) || e.acc != 85) begin
      errors++; $display("FAIL load_wins_acc: got %0d required 85", acc_out);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   lat, seen;
    load(3, 3, 3, 3, 10);
    send(pack(1, 1, 1, 1), -1);
    void'(sb.pop_back());
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < K; i++) mw[i] = 0;
    mb = 0;
    checks += 3;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_ready: got %0b required 1", in_ready);
    end
    if (out !== 1'b0 || acc_out !== '0) begin
      errors++; $display("FAIL abort_outs: got out=%0b acc=%0d required 0/0", out, acc_out);
    end
    seen = 0;
    for (int i = 0; i < K + 3; i++) begin
      if (out_valid) seen++;
      tick();
    end
    if (seen != 0) begin
      errors++; $display("FAIL abort_valid: got %0d pulses required 0", seen);
    end
    load(4, 0, 0, 1, -3);
    send(pack(50, 0, 0, 9), -1);
    wait_out(lat);
    e = sb.pop_front();
    checks += 2;
    if (acc_out !== AW'(e.acc) || e.acc != 206) begin
      errors++; $display("FAIL abort_next_acc: got %0d required 206", acc_out);
    end
    if (out !== 1'b0) begin
      errors++; $display("FAIL abort_next_out: got %0b required 0", out);
    end
  endtask

`ifdef PERCEPTRON_LEARN_EN
  task automatic test_learn();
    exp_t e;
    int   lat;
    load(120, 120, 120, 120, 0);
    send(pack(100, 100, 100, 100), 0);
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (acc_out !== AW'(e.acc) || out !== 1'b1) begin
      errors++; $display("FAIL learn_dec_pre: got %0d/%0b required %0d/1", acc_out, out, e.acc);
    end
    for (int i = 0; i < K; i++) mw[i] = 20;
    mb = -1;
    send(pack(1, 2, 3, 4), 0);
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (acc_out !== AW'(e.acc) || e.acc != 199) begin
      errors++; $display("FAIL learn_dec: got %0d required 199", acc_out);
    end
    load(100, 0, 0, 0, -20000);
    send(pack(100, 0, 0, 0), 1);
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (acc_out !== AW'(e.acc) || out !== 1'b0) begin
      errors++; $display("FAIL learn_inc_pre: got %0d/%0b required %0d/0", acc_out, out, e.acc);
    end
    mw[0] = 127;
    mb = -19999;
    send(pack(1, 0, 0, 0), 0);
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (acc_out !== AW'(e.acc) || e.acc != -19872) begin
      errors++; $display("FAIL learn_sat: got %0d required -19872", acc_out);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < K; i++) mw[i] = 0;
    test_reset();
    test_basic();
    test_threshold();
    test_signed();
    test_back_to_back();
    test_reset_mid();
`ifdef PERCEPTRON_LEARN_EN
    test_learn();
`endif
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
